// File: rtl/g_wb_arbiter.sv
// Writeback arbiter: three result sources, each with a 2-entry FIFO, share the
// register file's single writeback port through a round-robin scheduler.
module g_wb_arbiter #(
    parameter int W_RD  = 4,
    parameter int W_OPR = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           src_valid_i,
    input  logic [3*W_RD-1:0]    src_rd_i,
    input  logic [3*W_OPR-1:0]   src_data_i,
    output logic [2:0]           src_ready_o,
    output logic                 wb_o,
    output logic [W_RD-1:0]      wb_r_o,
    output logic [W_OPR-1:0]     result_o,
    output logic                 busy_o
);

    localparam int NSRC = 3;

    // Handshake: a source entry transfers on any rising edge where
    // src_valid_i[k] and src_ready_o[k] are both high; ready depends on
    // registered occupancy only, never on valid.

    logic [1:0]       cnt_q      [NSRC];
    logic [1:0]       cnt_d      [NSRC];
    logic             head_q     [NSRC];
    logic             head_d     [NSRC];
    logic             tail_q     [NSRC];
    logic             tail_d     [NSRC];
    logic [W_RD-1:0]  rd_mem_q   [NSRC][2];
    logic [W_RD-1:0]  rd_mem_d   [NSRC][2];
    logic [W_OPR-1:0] data_mem_q [NSRC][2];
    logic [W_OPR-1:0] data_mem_d [NSRC][2];

    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             wb_q, wb_d;
    logic [W_RD-1:0]  wb_r_q, wb_r_d;
    logic [W_OPR-1:0] result_q, result_d;

    logic [2:0]       push, pop;
    logic             win_vld;
    logic [1:0]       win_idx;
    logic [2:0]       cand;

    always_comb begin
        for (int k = 0; k < NSRC; k++) begin
            src_ready_o[k] = (cnt_q[k] != 2'd2);
        end
    end

    // Search rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3) for the first non-empty FIFO.
    always_comb begin
        win_vld = 1'b0;
        win_idx = rr_ptr_q;
        cand    = 3'd0;
        for (int i = 0; i < NSRC; i++) begin
            cand = {1'b0, rr_ptr_q} + 3'(i);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!win_vld && (cnt_q[cand[1:0]] != 2'd0)) begin
                win_vld = 1'b1;
                win_idx = cand[1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wb_d     = win_vld;
        wb_r_d   = wb_r_q;
        result_d = result_q;
        push     = '0;
        pop      = '0;
        for (int k = 0; k < NSRC; k++) begin
            cnt_d[k]  = cnt_q[k];
            head_d[k] = head_q[k];
            tail_d[k] = tail_q[k];
            for (int e = 0; e < 2; e++) begin
                rd_mem_d[k][e]   = rd_mem_q[k][e];
                data_mem_d[k][e] = data_mem_q[k][e];
            end
        end
        for (int k = 0; k < NSRC; k++) begin
            push[k] = src_valid_i[k] & src_ready_o[k];
            pop[k]  = win_vld & (win_idx == 2'(k));
            if (push[k]) begin
                rd_mem_d[k][tail_q[k]]   = src_rd_i[k*W_RD +: W_RD];
                data_mem_d[k][tail_q[k]] = src_data_i[k*W_OPR +: W_OPR];
                tail_d[k]                = ~tail_q[k];
            end
            if (pop[k]) begin
                head_d[k] = ~head_q[k];
            end
            cnt_d[k] = cnt_q[k] + 2'(push[k]) - 2'(pop[k]);
        end
        // Index and data hold their last values while idle.
        if (win_vld) begin
            wb_r_d   = rd_mem_q[win_idx][head_q[win_idx]];
            result_d = data_mem_q[win_idx][head_q[win_idx]];
            rr_ptr_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            wb_q     <= 1'b0;
            wb_r_q   <= '0;
            result_q <= '0;
            for (int k = 0; k < NSRC; k++) begin
                cnt_q[k]  <= '0;
                head_q[k] <= 1'b0;
                tail_q[k] <= 1'b0;
                for (int e = 0; e < 2; e++) begin
                    rd_mem_q[k][e]   <= '0;
                    data_mem_q[k][e] <= '0;
                end
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wb_q     <= wb_d;
            wb_r_q   <= wb_r_d;
            result_q <= result_d;
            for (int k = 0; k < NSRC; k++) begin
                cnt_q[k]  <= cnt_d[k];
                head_q[k] <= head_d[k];
                tail_q[k] <= tail_d[k];
                for (int e = 0; e < 2; e++) begin
                    rd_mem_q[k][e]   <= rd_mem_d[k][e];
                    data_mem_q[k][e] <= data_mem_d[k][e];
                end
            end
        end
    end

    assign wb_o     = wb_q;
    assign wb_r_o   = wb_r_q;
    assign result_o = result_q;
    assign busy_o   = (cnt_q[0] != 2'd0) | (cnt_q[1] != 2'd0) | (cnt_q[2] != 2'd0) | wb_q;

endmodule

// File: tb/tb_g_wb_arbiter.sv
// Directed bench for g_wb_arbiter: reset, single write, round-robin, fairness,
// backpressure, same-cycle push/pop and asynchronous reset mid-stream.
module tb_g_wb_arbiter;

    localparam int W_RD  = 4;
    localparam int W_OPR = 32;

    logic                clk;
    logic                rst_n;
    logic [2:0]          src_valid;
    logic [3*W_RD-1:0]   src_rd;
    logic [3*W_OPR-1:0]  src_data;
    logic [2:0]          src_ready;
    logic                wb;
    logic [W_RD-1:0]     wb_r;
    logic [W_OPR-1:0]    result;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;

    g_wb_arbiter #(.W_RD(W_RD), .W_OPR(W_OPR)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .src_valid_i(src_valid),
        .src_rd_i   (src_rd),
        .src_data_i (src_data),
        .src_ready_o(src_ready),
        .wb_o       (wb),
        .wb_r_o     (wb_r),
        .result_o   (result),
        .busy_o     (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reservation precondition: no source may push an rd that is still
    // awaiting its writeback.
    logic [15:0] pend_q;
    logic [15:0] push_mask;
    logic [15:0] clr_mask;

    always_comb begin
        push_mask = '0;
        for (int k = 0; k < 3; k++) begin
            if (src_valid[k] && src_ready[k]) begin
                push_mask[src_rd[k*W_RD +: W_RD]] = 1'b1;
            end
        end
        clr_mask = wb ? (16'h1 << wb_r) : 16'h0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            if (|push_mask) begin
                chk("rd_free", 64'(push_mask & pend_q & ~clr_mask), 64'h0);
            end
            pend_q <= (pend_q & ~clr_mask) | push_mask;
        end
    end

    // ---------------- drivers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [W_RD-1:0] rd,
                         input logic [W_OPR-1:0] data);
        src_valid[k]              = v;
        src_rd[k*W_RD +: W_RD]    = rd;
        src_data[k*W_OPR +: W_OPR] = data;
    endtask

    task automatic idle_all();
        src_valid = '0;
    endtask

    task automatic expect_wb(input string tag, input logic [W_RD-1:0] rd,
                             input logic [W_OPR-1:0] data);
        chk({tag, "_wb"},   64'(wb),     64'h1);
        chk({tag, "_rd"},   64'(wb_r),   64'(rd));
        chk({tag, "_data"}, 64'(result), 64'(data));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_wb"}, 64'(wb), 64'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        src_valid = '0;
        src_rd    = '0;
        src_data  = '0;
        #2;
        chk("rst_wb",     64'(wb),        64'h0);
        chk("rst_ready",  64'(src_ready), 64'h7);
        chk("rst_busy",   64'(busy),      64'h0);
        chk("rst_wb_r",   64'(wb_r),      64'h0);
        chk("rst_result", 64'(result),    64'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Round-robin from rr_ptr=0: all three push together.
        drive(0, 1'b1, 4'd1, 32'hA000_0001);
        drive(1, 1'b1, 4'd2, 32'hA000_0002);
        drive(2, 1'b1, 4'd3, 32'hA000_0003);
        cyc();
        idle_all();
        expect_idle("rr_e0");
        chk("rr_busy", 64'(busy), 64'h1);
        cyc(); expect_wb("rr_1", 4'd1, 32'hA000_0001);
        cyc(); expect_wb("rr_2", 4'd2, 32'hA000_0002);
        cyc(); expect_wb("rr_3", 4'd3, 32'hA000_0003);
        cyc(); expect_idle("rr_end");
        chk("rr_end_busy", 64'(busy), 64'h0);

        // Single write; rr_ptr is back at 0 so source 0 wins immediately.
        drive(0, 1'b1, 4'd5, 32'hDEAD_BEEF);
        cyc();
        idle_all();
        expect_idle("sw_e0");
        cyc();
        expect_wb("sw", 4'd5, 32'hDEAD_BEEF);
        chk("sw_busy", 64'(busy), 64'h1);
        cyc();
        expect_idle("sw_after");
        chk("sw_hold_rd",   64'(wb_r),   64'h5);
        chk("sw_hold_data", 64'(result), 64'hDEAD_BEEF);
        chk("sw_busy_off",  64'(busy),   64'h0);

        // Fairness: rr_ptr=1, sources 0 and 2 loaded twice; order 2,0,2,0.
        drive(0, 1'b1, 4'd6, 32'h6000_0006);
        drive(2, 1'b1, 4'd7, 32'h7000_0007);
        cyc();
        expect_idle("fair_e0");
        drive(0, 1'b1, 4'd8, 32'h8000_0008);
        drive(2, 1'b1, 4'd9, 32'h9000_0009);
        cyc();
        idle_all();
        expect_wb("fair_1", 4'd7, 32'h7000_0007);
        chk("fair_ready", 64'(src_ready), 64'h6);
        cyc(); expect_wb("fair_2", 4'd6, 32'h6000_0006);
        cyc(); expect_wb("fair_3", 4'd9, 32'h9000_0009);
        cyc(); expect_wb("fair_4", 4'd8, 32'h8000_0008);
        cyc(); expect_idle("fair_end");

        // Backpressure on source 1 with rr_ptr=1.
        drive(0, 1'b1, 4'd11, 32'hA0A0_000B);
        drive(2, 1'b1, 4'd10, 32'hC0C0_000A);
        cyc();
        expect_idle("bp_e1");
        drive(0, 1'b1, 4'd12, 32'hA0A0_000C);
        drive(2, 1'b1, 4'd13, 32'hC0C0_000D);
        drive(1, 1'b1, 4'd1,  32'hB0B0_0001);
        cyc();
        expect_wb("bp_c0", 4'd10, 32'hC0C0_000A);
        drive(0, 1'b0, 4'd0, 32'h0);
        drive(2, 1'b0, 4'd0, 32'h0);
        drive(1, 1'b1, 4'd2, 32'hB0B0_0002);
        cyc();
        expect_wb("bp_a0", 4'd11, 32'hA0A0_000B);
        chk("bp_full_ready", 64'(src_ready), 64'h5);
        drive(1, 1'b1, 4'd3, 32'hB0B0_0003);
        cyc();
        expect_wb("bp_b0", 4'd1, 32'hB0B0_0001);
        chk("bp_reopen_ready", 64'(src_ready), 64'h7);
        cyc();
        expect_wb("bp_c1", 4'd13, 32'hC0C0_000D);
        chk("bp_refull_ready", 64'(src_ready[1]), 64'h0);
        idle_all();
        cyc(); expect_wb("bp_a1", 4'd12, 32'hA0A0_000C);
        cyc(); expect_wb("bp_b1", 4'd2,  32'hB0B0_0002);
        cyc(); expect_wb("bp_b2", 4'd3,  32'hB0B0_0003);
        cyc(); expect_idle("bp_end");
        chk("bp_end_busy", 64'(busy), 64'h0);

        // Same-cycle push/pop on source 2 (rr_ptr=2).
        drive(2, 1'b1, 4'd4, 32'h4444_0004);
        cyc();
        expect_idle("pp_e1");
        drive(2, 1'b1, 4'd5, 32'h5555_0005);
        cyc();
        idle_all();
        expect_wb("pp_0", 4'd4, 32'h4444_0004);
        chk("pp_ready", 64'(src_ready), 64'h7);
        cyc();
        expect_wb("pp_1", 4'd5, 32'h5555_0005);
        cyc();
        expect_idle("pp_end");
        chk("pp_end_busy", 64'(busy), 64'h0);

        // Asynchronous reset with two entries queued in source 1 (rr_ptr=0).
        drive(0, 1'b1, 4'd6, 32'h6666_0006);
        drive(1, 1'b1, 4'd7, 32'h7777_0007);
        cyc();
        drive(0, 1'b0, 4'd0, 32'h0);
        drive(1, 1'b1, 4'd8, 32'h8888_0008);
        cyc();
        idle_all();
        expect_wb("ar_pre", 4'd6, 32'h6666_0006);
        chk("ar_pre_ready", 64'(src_ready), 64'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_wb",     64'(wb),        64'h0);
        chk("ar_ready",  64'(src_ready), 64'h7);
        chk("ar_busy",   64'(busy),      64'h0);
        chk("ar_wb_r",   64'(wb_r),      64'h0);
        chk("ar_result", 64'(result),    64'h0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_idle("ar_post");
            chk("ar_post_busy", 64'(busy), 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/g_wb_arbiter.md
# g_wb_arbiter

Writeback arbiter for the 16-entry general register file. Three execution sources share the file's single writeback port (wb / wb_r / result): source 0 is the ALU, source 1 is the load unit and source 2 is the multiplier. Each source pushes results into its own 2-entry FIFO through a valid/ready handshake. A round-robin scheduler pops one entry per cycle and drives a registered writeback to the register file, which clears that register's reservation bit.

## Interface
- W_RD, 4, register index width (16 registers)
- W_OPR, 32, operand/result width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- src_valid_i  in  3  per-source result valid; bit k = source k
- src_rd_i  in  3*W_RD  destination register; source k in bits [k*W_RD +: W_RD]
- src_data_i  in  3*W_OPR  result value; source k in bits [k*W_OPR +: W_OPR]
- src_ready_o  out  3  per-source FIFO can accept
- wb_o  out  1  writeback strobe to register file (wb_i)
- wb_r_o  out  W_RD  writeback register index (wb_r_i)
- result_o  out  W_OPR  writeback data (result_i)
- busy_o  out  1  any FIFO non-empty or wb_o high

## Operation
- Per-source FIFO:
  - 2 entries of {rd, data}, with 2-bit count, head pointer and tail pointer.
  - Push when src_valid_i[k] & src_ready_o[k].
  - src_ready_o[k] = (count_k != 2). It is a function of registered state only and never depends on src_valid_i.
  - A full FIFO deasserts ready even in a cycle where it is also popped.
  - Push and pop in the same cycle are allowed on a 1-entry FIFO: count stays 1, both pointers advance.
- Scheduler:
  - rr_ptr is 2 bits, values 0..2, reset to 0.
  - Candidate set = sources with count != 0.
  - Winner = first candidate found searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - When a winner exists: pop its head, and register wb_o=1, wb_r_o=head.rd, result_o=head.data. Then rr_ptr <= (winner+1) mod 3.
  - When no candidate exists: wb_o <= 0 and rr_ptr holds. wb_r_o and result_o hold their last values.
  - The arbiter issues at most one writeback per cycle.
- Ordering:
  - Entries from one source retire in push order.
  - Between sources there is no ordering guarantee. The reservation scoreboard forbids two outstanding writes to the same rd, so the arbiter does not check rd conflicts. The bench asserts the precondition.
- busy_o = (count_0|count_1|count_2 != 0) | wb_o. It is combinational from registered state.
- Reset (asserted, reset=0):
  - Immediate, regardless of clk.
  - All counts and pointers = 0, rr_ptr = 0, wb_o = 0, wb_r_o = 0, result_o = 0.
  - src_ready_o = 3'b111, busy_o = 0.
  - Entries held in the FIFOs are discarded. Reset mid-operation drops pending writebacks; the register file reset clears the matching reservations.

## Timing
- Push accepted at edge E0. The entry is eligible in the cycle after E0. At the earliest it is popped at edge E1, with wb_o high in the cycle after E1. The register file captures it at E2.
- Minimum latency from accept to the wb_o cycle is 1 cycle. Contention adds 1 cycle per earlier winner.
- A source with a non-empty FIFO waits at most 2 pops by other sources before it wins (3-way round-robin, no starvation).
- Sustained throughput: one writeback per cycle while any FIFO is non-empty. Each single source can sustain 1 push per cycle when it alone is active.
- A full FIFO deasserts src_ready_o in the cycle after the edge that filled it. src_ready_o reasserts in the cycle after the pop edge.

## Test plan
- Reset: drive reset=0 mid-stream with 2 entries queued in source 1 -> wb_o=0, src_ready_o=3'b111, busy_o=0 immediately. No writeback follows after release.
- Single write: source 0 pushes rd=5, data=32'hDEADBEEF at edge E0 -> wb_o=1, wb_r_o=5, result_o=32'hDEADBEEF exactly in the cycle after E1. wb_o=0 in the next cycle.
- Round-robin: all three sources push one entry in the same cycle (rd 1/2/3) with rr_ptr=0 -> wb_r_o sequence is 1, 2, 3 on consecutive cycles. rr_ptr ends at 0.
- Fairness under load: sources 0 and 2 each hold 2 queued entries, source 1 is empty, rr_ptr=1 -> winner order is 2, 0, 2, 0. No cycle passes without a writeback until all four entries drain.
- Backpressure: source 1 pushes 3 consecutive cycles while sources 0 and 2 are kept non-empty -> src_ready_o[1] drops to 0 once count=2. The third value is held by the source and accepted after a pop. All three values retire in push order.
- Same-cycle push/pop: source 2 has 1 entry and pushes again in the cycle it wins -> count stays 1, both values written back in order on consecutive wins.
